// File: rtl/aes_pipeline_stage4.sv
// -----------------------------------------------------------------------------
// aes_pipeline_stage4
//   Stage 4 of the AES-GCM encrypt pipeline. It applies one AES round group to
//   the three in-flight states (H, J0, CB). It adds valid/ready flow control
//   through a main register (M, which drives the outputs) and a one-beat skid
//   register (S). It also tracks the block position of each beat inside its
//   GCM instance.
//
//   Round group g is one full AES round: SubBytes, ShiftRows, MixColumns, and
//   then AddRoundKey. The round key is the g-th 128-bit word of the key
//   schedule, counted from the MSB end (round key 0 = bits 1407:1280).
//   The round is computed when a beat is loaded into M, so every output comes
//   straight from a register.
//
//   Optional build macro: AES_STAGE4_PARITY_EN adds o_parity[0:2]. These bits
//   are the even parity of the pre-round H, CB and J0 held in M.
//
// Ports
//   clk, rst_n             clock, asynchronous active-low reset
//   i_valid / o_ready      upstream handshake (o_ready registered, = !S full)
//   i_phase                phase code, 3'b000 marks a bubble
//   i_h, i_j0, i_cb        states from stage 3
//   i_plain_text, i_aad    carried data
//   i_instance_size        low CNT_W bits = plaintext bit length
//   i_key_schedule         expanded key (11 x 128 bits)
//   o_valid / i_ready      downstream handshake
//   o_phase .. o_key_schedule  beat held in M (states after the round group)
//   o_block_idx, o_last    block position within the instance
// -----------------------------------------------------------------------------
module aes_pipeline_stage4 #(
    parameter int CNT_W        = 32,
    parameter int H_ROUND_GRP  = 5,
    parameter int CB_ROUND_GRP = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [2:0]        i_phase,
    input  logic [127:0]      i_h,
    input  logic [127:0]      i_j0,
    input  logic [127:0]      i_cb,
    input  logic [127:0]      i_plain_text,
    input  logic [127:0]      i_aad,
    input  logic [127:0]      i_instance_size,
    input  logic [1407:0]     i_key_schedule,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [2:0]        o_phase,
    output logic [127:0]      o_h,
    output logic [127:0]      o_encrypted_j0,
    output logic [127:0]      o_encrypted_cb,
    output logic [127:0]      o_plain_text,
    output logic [127:0]      o_aad,
    output logic [127:0]      o_instance_size,
    output logic [1407:0]     o_key_schedule,
    output logic [CNT_W-1:0]  o_block_idx,
`ifdef AES_STAGE4_PARITY_EN
    output logic [0:2]        o_parity,
`endif
    output logic              o_last
);

    localparam logic [CNT_W:0]   ROUND_UP_C = (CNT_W+1)'(127);
    localparam logic [CNT_W:0]   NBLK_ONE_C = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] IDX_ONE_C  = CNT_W'(1);

    typedef struct packed {
        logic [2:0]       phase;
        logic [127:0]     h;
        logic [127:0]     j0;
        logic [127:0]     cb;
        logic [127:0]     pt;
        logic [127:0]     aad;
        logic [127:0]     size;
        logic [1407:0]    ks;
        logic [CNT_W-1:0] idx;
        logic             last;
    } beat_t;

    typedef enum logic [0:0] { ST_IDLE = 1'b0, ST_RUN = 1'b1 } trk_state_t;

    // ---------------- AES round helpers ----------------
    function automatic logic [7:0] fn_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] fn_gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = fn_xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); 0 maps to 0.
    function automatic logic [7:0] fn_ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = fn_gmul(sq, sq);
            r  = fn_gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] fn_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = fn_ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Byte i of a state is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] fn_aes_encrypt_stage(input logic [127:0]  st,
                                                          input logic [1407:0] ks,
                                                          input int            grp);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] mix;
        mix = 128'h0;
        for (int i = 0; i < 16; i++) begin
            sb[i] = fn_sbox(st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[4*c+r] = sb[4*((c+r)%4)+r];
            end
        end
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            mix[127-32*c -: 8]    = fn_xtime(a0) ^ fn_xtime(a1) ^ a1 ^ a2 ^ a3;
            mix[127-32*c-8 -: 8]  = a0 ^ fn_xtime(a1) ^ fn_xtime(a2) ^ a2 ^ a3;
            mix[127-32*c-16 -: 8] = a0 ^ a1 ^ fn_xtime(a2) ^ fn_xtime(a3) ^ a3;
            mix[127-32*c-24 -: 8] = fn_xtime(a0) ^ a0 ^ a1 ^ a2 ^ fn_xtime(a3);
        end
        return mix ^ ks[1407-128*grp -: 128];
    endfunction

    function automatic logic fn_parity128(input logic [127:0] d);
        return ^d;
    endfunction

    // ---------------- signals ----------------
    trk_state_t       st_r, st_nxt_s;
    logic [CNT_W:0]   rem_r, rem_nxt_s;
    logic [CNT_W-1:0] idx_r, idx_nxt_s;
    logic [CNT_W:0]   nblk_s;
    logic [CNT_W-1:0] trk_idx_s;
    logic             trk_last_s;

    beat_t            in_beat_s, s_beat_r, ld_beat_s;
    logic             s_full_r, s_full_nxt_s, m_valid_nxt_s;
    logic             accept_s, drain_s, m_free_s, load_m_s, s_load_s;
    logic [127:0]     ld_h_rnd_s, ld_j0_rnd_s, ld_cb_rnd_s;

    assign accept_s = i_valid && o_ready;
    assign drain_s  = o_valid && i_ready;
    assign m_free_s = !o_valid || drain_s;
    // While S is full o_ready is low, so a fresh beat can never race the S->M move.
    assign load_m_s = m_free_s && (s_full_r || accept_s);
    assign s_load_s = accept_s && !m_free_s;

    // Ceil(len/128) at CNT_W+1 bits so len = 2^CNT_W-1 does not wrap.
    assign nblk_s = ({1'b0, i_instance_size[CNT_W-1:0]} + ROUND_UP_C) >> 7;

    // Block tracker next state and the idx/last tag for the incoming beat.
    always_comb begin
        st_nxt_s   = st_r;
        rem_nxt_s  = rem_r;
        idx_nxt_s  = idx_r;
        trk_idx_s  = '0;
        trk_last_s = 1'b0;
        if (accept_s && (i_phase != 3'b000)) begin
            case (st_r)
                ST_IDLE: begin
                    idx_nxt_s = '0;
                    if (nblk_s <= NBLK_ONE_C) begin
                        trk_last_s = 1'b1;
                        st_nxt_s   = ST_IDLE;
                    end else begin
                        rem_nxt_s = nblk_s - NBLK_ONE_C;
                        st_nxt_s  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    trk_idx_s = idx_r + IDX_ONE_C;
                    idx_nxt_s = idx_r + IDX_ONE_C;
                    if (rem_r == NBLK_ONE_C) begin
                        trk_last_s = 1'b1;
                        st_nxt_s   = ST_IDLE;
                    end else begin
                        rem_nxt_s = rem_r - NBLK_ONE_C;
                    end
                end
                default: begin
                    st_nxt_s = ST_IDLE;
                end
            endcase
        end else begin
            st_nxt_s = st_r;
        end
    end

    // Block tracker state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_r  <= ST_IDLE;
            rem_r <= '0;
            idx_r <= '0;
        end else begin
            st_r  <= st_nxt_s;
            rem_r <= rem_nxt_s;
            idx_r <= idx_nxt_s;
        end
    end

    assign in_beat_s = {i_phase, i_h, i_j0, i_cb, i_plain_text, i_aad,
                        i_instance_size, i_key_schedule, trk_idx_s, trk_last_s};

    // Choose the beat that enters M: the parked beat has priority to keep order.
    always_comb begin
        ld_beat_s = in_beat_s;
        if (s_full_r) begin
            ld_beat_s = s_beat_r;
        end else begin
            ld_beat_s = in_beat_s;
        end
    end

    // Occupancy bookkeeping for M and S.
    always_comb begin
        s_full_nxt_s  = s_full_r;
        m_valid_nxt_s = o_valid;
        if (m_free_s) begin
            m_valid_nxt_s = s_full_r || accept_s;
            s_full_nxt_s  = 1'b0;
        end else begin
            m_valid_nxt_s = 1'b1;
            s_full_nxt_s  = s_full_r || accept_s;
        end
    end

    assign ld_h_rnd_s  = fn_aes_encrypt_stage(ld_beat_s.h,  ld_beat_s.ks, H_ROUND_GRP);
    assign ld_j0_rnd_s = fn_aes_encrypt_stage(ld_beat_s.j0, ld_beat_s.ks, CB_ROUND_GRP);
    assign ld_cb_rnd_s = fn_aes_encrypt_stage(ld_beat_s.cb, ld_beat_s.ks, CB_ROUND_GRP);

    // Skid register and registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_full_r <= 1'b0;
            s_beat_r <= '0;
            o_ready  <= 1'b1;
        end else begin
            s_full_r <= s_full_nxt_s;
            o_ready  <= !s_full_nxt_s;
            if (s_load_s) begin
                s_beat_r <= in_beat_s;
            end
        end
    end

    // Main register M: it drives every output and holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid         <= 1'b0;
            o_phase         <= 3'b000;
            o_h             <= '0;
            o_encrypted_j0  <= '0;
            o_encrypted_cb  <= '0;
            o_plain_text    <= '0;
            o_aad           <= '0;
            o_instance_size <= '0;
            o_key_schedule  <= '0;
            o_block_idx     <= '0;
            o_last          <= 1'b0;
`ifdef AES_STAGE4_PARITY_EN
            o_parity        <= 3'b000;
`endif
        end else begin
            o_valid <= m_valid_nxt_s;
            if (load_m_s) begin
                o_phase         <= ld_beat_s.phase;
                o_h             <= ld_h_rnd_s;
                o_encrypted_j0  <= ld_j0_rnd_s;
                o_encrypted_cb  <= ld_cb_rnd_s;
                o_plain_text    <= ld_beat_s.pt;
                o_aad           <= ld_beat_s.aad;
                o_instance_size <= ld_beat_s.size;
                o_key_schedule  <= ld_beat_s.ks;
                o_block_idx     <= ld_beat_s.idx;
                o_last          <= ld_beat_s.last;
`ifdef AES_STAGE4_PARITY_EN
                o_parity        <= {fn_parity128(ld_beat_s.h), fn_parity128(ld_beat_s.cb),
                                    fn_parity128(ld_beat_s.j0)};
`endif
            end
        end
    end

endmodule

// File: tb/tb_aes_pipeline_stage4.sv
module tb_aes_pipeline_stage4;

    localparam int CNT_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              i_valid, o_ready, o_valid, i_ready, o_last;
    logic [2:0]        i_phase, o_phase;
    logic [127:0]      i_h, i_j0, i_cb, i_plain_text, i_aad, i_instance_size;
    logic [1407:0]     i_key_schedule, o_key_schedule;
    logic [127:0]      o_h, o_encrypted_j0, o_encrypted_cb, o_plain_text, o_aad, o_instance_size;
    logic [CNT_W-1:0]  o_block_idx;
`ifdef AES_STAGE4_PARITY_EN
    logic [0:2]        o_parity;
`endif

    always #5 clk = ~clk;

    aes_pipeline_stage4 #(.CNT_W(CNT_W), .H_ROUND_GRP(5), .CB_ROUND_GRP(3)) dut (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready), .i_phase(i_phase),
        .i_h(i_h), .i_j0(i_j0), .i_cb(i_cb), .i_plain_text(i_plain_text), .i_aad(i_aad),
        .i_instance_size(i_instance_size), .i_key_schedule(i_key_schedule),
        .o_valid(o_valid), .i_ready(i_ready), .o_phase(o_phase), .o_h(o_h),
        .o_encrypted_j0(o_encrypted_j0), .o_encrypted_cb(o_encrypted_cb),
        .o_plain_text(o_plain_text), .o_aad(o_aad), .o_instance_size(o_instance_size),
        .o_key_schedule(o_key_schedule), .o_block_idx(o_block_idx),
`ifdef AES_STAGE4_PARITY_EN
        .o_parity(o_parity),
`endif
        .o_last(o_last)
    );

    typedef struct {
        logic [2:0]    phase;
        logic [127:0]  h, j0, cb, pt, aad, size;
        logic [1407:0] ks;
        logic [31:0]   idx;
        logic          last;
    } exp_t;

    typedef struct {
        logic [2:0]  phase;
        logic [31:0] len;
        logic [31:0] exp_idx;
        logic        exp_last;
    } vec_t;

    exp_t         sb_q[$];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t [256];
    longint       trk_nblk = 1;
    longint       trk_pos  = 0;
    logic         stall_prev = 1'b0;
    logic [127:0] hold_h;
    logic [31:0]  hold_idx;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // GF(2^8) multiply by shift-and-add on plain integers.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        int x, y, p;
        x = int'(a);
        y = int'(b);
        p = 0;
        while (y != 0) begin
            if ((y & 1) != 0) p = p ^ x;
            x = x << 1;
            if ((x & 256) != 0) x = x ^ 283;
            y = y >> 1;
        end
        return p[7:0];
    endfunction

    // S-box table: brute-force inverse followed by the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            logic [7:0] s;
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            end
            sbox_t[x] = s;
        end
    endtask

    // One AES round on a 4x4 byte matrix s[row][col] = byte row+4*col.
    function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [1407:0] ks, input int g);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] o;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                s[r][c] = sbox_t[st[127-8*(r+4*c) -: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                t[r][c] = s[r][(c+r)%4];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) acc = acc ^ ref_mul(coef[(k-r+4)%4], t[k][c]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        return o ^ ks[1407-128*g -: 128];
    endfunction

    // Reference for an accepted beat: rounds plus block position within the instance.
    task automatic push_model();
        exp_t   e;
        longint len;
        e.phase = i_phase; e.pt = i_plain_text; e.aad = i_aad;
        e.size = i_instance_size; e.ks = i_key_schedule;
        e.h  = ref_round(i_h,  i_key_schedule, 5);
        e.j0 = ref_round(i_j0, i_key_schedule, 3);
        e.cb = ref_round(i_cb, i_key_schedule, 3);
        if (i_phase != 3'b000) begin
            if (trk_pos == 0) begin
                len = longint'(i_instance_size[31:0]);
                trk_nblk = (len + 127) / 128;
                if (trk_nblk < 1) trk_nblk = 1;
            end
            e.idx  = 32'(trk_pos);
            e.last = (trk_pos == trk_nblk - 1);
            trk_pos = e.last ? 0 : trk_pos + 1;
        end else begin
            e.idx = 32'h0;
            e.last = 1'b0;
        end
        sb_q.push_back(e);
    endtask

    task automatic compare_beat(input exp_t e);
        chk("o_phase", 128'(o_phase), 128'(e.phase));
        chk("o_h", o_h, e.h);
        chk("o_encrypted_j0", o_encrypted_j0, e.j0);
        chk("o_encrypted_cb", o_encrypted_cb, e.cb);
        chk("o_plain_text", o_plain_text, e.pt);
        chk("o_aad", o_aad, e.aad);
        chk("o_instance_size", o_instance_size, e.size);
        for (int k = 0; k < 11; k++) chk("o_key_schedule", o_key_schedule[128*k +: 128], e.ks[128*k +: 128]);
        chk("o_block_idx", 128'(o_block_idx), 128'(e.idx));
        chk("o_last", 128'(o_last), 128'(e.last));
    endtask

    // Observe the handshake for this cycle, then advance one clock.
    task automatic cycle();
        #1;
        if (rst_n) begin
            if (stall_prev) begin
                chk("hold_valid", 128'(o_valid), 128'(1'b1));
                chk("hold_h", o_h, hold_h);
                chk("hold_idx", 128'(o_block_idx), 128'(hold_idx));
            end
            if (o_valid && i_ready) begin
                if (sb_q.size() == 0) chk("unexpected_beat", 128'(o_valid), 128'(1'b0));
                else compare_beat(sb_q.pop_front());
            end
            stall_prev = o_valid && !i_ready;
            hold_h = o_h;
            hold_idx = o_block_idx;
            if (i_valid && o_ready) push_model();
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive(input logic v, input logic [2:0] ph, input logic [31:0] len);
        i_valid = v; i_phase = ph;
        i_h = rand128(); i_j0 = rand128(); i_cb = rand128();
        i_plain_text = rand128(); i_aad = rand128();
        i_instance_size = {$urandom, $urandom, $urandom, len};
        for (int k = 0; k < 44; k++) i_key_schedule[32*k +: 32] = $urandom;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 128'(o_valid), 128'(1'b0));
        chk({tag, "_ready"}, 128'(o_ready), 128'(1'b1));
        chk({tag, "_h"}, o_h, 128'h0);
        chk({tag, "_cb"}, o_encrypted_cb, 128'h0);
        chk({tag, "_j0"}, o_encrypted_j0, 128'h0);
        chk({tag, "_pt"}, o_plain_text, 128'h0);
        chk({tag, "_ks_any"}, 128'(|o_key_schedule), 128'(1'b0));
        chk({tag, "_idx"}, 128'(o_block_idx), 128'h0);
        chk({tag, "_last"}, 128'(o_last), 128'(1'b0));
    endtask

    task automatic apply_reset_mid();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        sb_q.delete();
        trk_pos = 0;
        stall_prev = 1'b0;
    endtask

    vec_t tbl [10];

    initial begin
        tbl[0] = '{3'd1, 32'd128, 32'd0, 1'b1};
        tbl[1] = '{3'd1, 32'd300, 32'd0, 1'b0};
        tbl[2] = '{3'd1, 32'd300, 32'd1, 1'b0};
        tbl[3] = '{3'd0, 32'd300, 32'd0, 1'b0};
        tbl[4] = '{3'd1, 32'd300, 32'd2, 1'b1};
        tbl[5] = '{3'd2, 32'd0,   32'd0, 1'b1};
        tbl[6] = '{3'd3, 32'd129, 32'd0, 1'b0};
        tbl[7] = '{3'd3, 32'd129, 32'd1, 1'b1};
        tbl[8] = '{3'd4, 32'd256, 32'd0, 1'b0};
        tbl[9] = '{3'd4, 32'd256, 32'd1, 1'b1};

        build_sbox();
        chk("sbox_00", 128'(sbox_t[8'h00]), 128'(8'h63));
        chk("sbox_53", 128'(sbox_t[8'h53]), 128'(8'hed));

        // Reset with a beat offered.
        rst_n = 1'b0;
        i_ready = 1'b1;
        drive(1'b1, 3'd1, 32'd128);
        repeat (3) begin
            @(negedge clk);
            #1;
            chk_reset_outputs("rst");
        end
        rst_n = 1'b1;
        // Single-block beat: visible after one edge, for exactly one cycle.
        drive(1'b1, 3'd1, 32'd128);
        cycle();
        chk("single_valid", 128'(o_valid), 128'(1'b1));
        chk("single_idx", 128'(o_block_idx), 128'h0);
        chk("single_last", 128'(o_last), 128'(1'b1));
        drive(1'b0, 3'd0, 32'd0);
        cycle();
        chk("single_gone", 128'(o_valid), 128'(1'b0));

        // Back-to-back table of instances, bubbles and length edge cases.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, tbl[k].phase, tbl[k].len);
            cycle();
            chk("tbl_valid", 128'(o_valid), 128'(1'b1));
            chk("tbl_idx", 128'(o_block_idx), 128'(tbl[k].exp_idx));
            chk("tbl_last", 128'(o_last), 128'(tbl[k].exp_last));
        end
        drive(1'b0, 3'd0, 32'd0);
        cycle();

        // Stall: three beats offered while the consumer is blocked.
        i_ready = 1'b0;
        drive(1'b1, 3'd1, 32'd384);
        cycle();
        drive(1'b1, 3'd1, 32'd384);
        cycle();
        chk("stall_ready_low", 128'(o_ready), 128'(1'b0));
        drive(1'b1, 3'd1, 32'd384);
        cycle();
        cycle();
        chk("stall_ready_still_low", 128'(o_ready), 128'(1'b0));
        chk("stall_queue", 128'(sb_q.size()), 128'd2);
        i_ready = 1'b1;
        cycle();
        cycle();
        drive(1'b0, 3'd0, 32'd0);
        cycle();
        cycle();
        chk("stall_drained", 128'(sb_q.size()), 128'd0);

        // Largest length: no wrap in the block count, then reset mid-instance.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 3'd5, 32'hFFFF_FFFF);
            cycle();
            chk("big_idx", 128'(o_block_idx), 128'(k));
            chk("big_last", 128'(o_last), 128'(1'b0));
        end
        apply_reset_mid();
        cycle();
        rst_n = 1'b1;
        drive(1'b1, 3'd1, 32'd128);
        cycle();
        chk("after_rst_idx", 128'(o_block_idx), 128'h0);
        chk("after_rst_last", 128'(o_last), 128'(1'b1));
        drive(1'b0, 3'd0, 32'd0);
        cycle();

        // Randomised traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            drive(($urandom_range(0, 3) != 0),
                  (($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom_range(1, 7))),
                  32'($urandom_range(0, 700)));
            i_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drive(1'b0, 3'd0, 32'd0);
        i_ready = 1'b1;
        repeat (5) cycle();
        chk("final_queue_empty", 128'(sb_q.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
